// File: rtl/cache_line_refill_unit.sv
// Line refill engine: optional dirty-victim writeback, then word-by-word fetch of the
// missed line from 32-bit backing memory, returned as one line over valid/ready.
module cache_line_refill_unit #(
    parameter int unsigned LINE_BITS  = 1024,
    parameter int unsigned WORD_BITS  = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_wb,
    input  logic [ADDR_WIDTH-1:0] req_wb_addr,
    input  logic [LINE_BITS-1:0]  req_wb_line,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_BITS-1:0]  resp_line,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [WORD_BITS-1:0]  mem_wdata,
    input  logic                  mem_rdata_valid,
    input  logic [WORD_BITS-1:0]  mem_rdata
);
    localparam int unsigned WORDS = LINE_BITS / WORD_BITS;
    localparam int unsigned OFFS  = $clog2(LINE_BITS / 8);
    localparam int unsigned IDXW  = $clog2(WORDS);
    localparam int unsigned CW    = IDXW + 1;
    localparam int unsigned BSH   = $clog2(WORD_BITS / 8);
    localparam int unsigned BASEW = ADDR_WIDTH - OFFS;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_RESP} state_e;

    state_e                             state_q, state_d;
    logic                               rdy_q;
    logic [BASEW-1:0]                   line_base_q, line_base_d;
    logic [BASEW-1:0]                   wb_base_q, wb_base_d;
    logic [WORDS-1:0][WORD_BITS-1:0]    wb_line_q, wb_line_d;
    logic [WORDS-1:0][WORD_BITS-1:0]    line_buf_q, line_buf_d;
    logic [IDXW-1:0]                    wcnt_q, wcnt_d;
    logic [CW-1:0]                      ccnt_q, ccnt_d;
    logic [CW-1:0]                      dcnt_q, dcnt_d;
    logic                               stg_vld_q, stg_vld_d;
    logic [WORD_BITS-1:0]               stg_data_q, stg_data_d;
    logic [IDXW-1:0]                    stg_idx_q, stg_idx_d;

    logic accept;
    logic cmd_fire;
    logic rx_take;
    logic last_wr;
    logic line_done;

    assign accept    = (state_q == S_IDLE) && req_valid && rdy_q;
    assign cmd_fire  = mem_cmd_valid && mem_cmd_ready;
    // Returns are only accepted against outstanding reads; stray pulses drop here.
    assign rx_take   = mem_rdata_valid && (ccnt_q != dcnt_q);
    assign last_wr   = (state_q == S_WB) && cmd_fire && (wcnt_q == IDXW'(WORDS - 1));
    assign line_done = stg_vld_q && (stg_idx_q == IDXW'(WORDS - 1));

    assign req_ready = rdy_q;
    assign resp_line = line_buf_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept)     state_d = req_wb ? S_WB : S_RD;
            S_WB:   if (last_wr)    state_d = S_RD;
            S_RD:   if (line_done)  state_d = S_RESP;
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wdata     = '0;
        resp_valid    = 1'b0;
        unique case (state_q)
            S_WB: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = 1'b1;
                mem_cmd_addr  = {wb_base_q, {OFFS{1'b0}}} + (ADDR_WIDTH'(wcnt_q) << BSH);
                mem_wdata     = wb_line_q[wcnt_q];
            end
            S_RD: begin
                if (ccnt_q < CW'(WORDS)) begin
                    mem_cmd_valid = 1'b1;
                    mem_cmd_addr  = {line_base_q, {OFFS{1'b0}}} + (ADDR_WIDTH'(ccnt_q) << BSH);
                end
            end
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: request latch, counters, return staging, line assembly
    always_comb begin
        line_base_d = line_base_q;
        wb_base_d   = wb_base_q;
        wb_line_d   = wb_line_q;
        line_buf_d  = line_buf_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        dcnt_d      = dcnt_q;
        stg_vld_d   = 1'b0;
        stg_data_d  = stg_data_q;
        stg_idx_d   = stg_idx_q;

        if (accept) begin
            line_base_d = req_addr[ADDR_WIDTH-1:OFFS];
            wb_base_d   = req_wb_addr[ADDR_WIDTH-1:OFFS];
            wb_line_d   = req_wb_line;
            wcnt_d      = '0;
            ccnt_d      = '0;
            dcnt_d      = '0;
        end
        if ((state_q == S_WB) && cmd_fire) begin
            wcnt_d = last_wr ? '0 : wcnt_q + 1'b1;
        end
        if ((state_q == S_RD) && cmd_fire) begin
            ccnt_d = ccnt_q + 1'b1;
        end
        if (rx_take) begin
            dcnt_d     = dcnt_q + 1'b1;
            stg_vld_d  = 1'b1;
            stg_data_d = mem_rdata;
            stg_idx_d  = dcnt_q[IDXW-1:0];
        end
        if (stg_vld_q) begin
            line_buf_d[stg_idx_q] = stg_data_q;
        end
    end

    // Datapath registers; req_ready is registered so it stays low throughout reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q       <= 1'b0;
            line_base_q <= '0;
            wb_base_q   <= '0;
            wb_line_q   <= '0;
            line_buf_q  <= '0;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            dcnt_q      <= '0;
            stg_vld_q   <= 1'b0;
            stg_data_q  <= '0;
            stg_idx_q   <= '0;
        end else begin
            rdy_q       <= (state_d == S_IDLE);
            line_base_q <= line_base_d;
            wb_base_q   <= wb_base_d;
            wb_line_q   <= wb_line_d;
            line_buf_q  <= line_buf_d;
            wcnt_q      <= wcnt_d;
            ccnt_q      <= ccnt_d;
            dcnt_q      <= dcnt_d;
            stg_vld_q   <= stg_vld_d;
            stg_data_q  <= stg_data_d;
            stg_idx_q   <= stg_idx_d;
        end
    end

endmodule

// File: tb/tb_cache_line_refill_unit.sv
// Directed bench for cache_line_refill_unit with an in-order memory model that
// logs commands and returns addr^0xA5A5A5A5 after a configurable delay.
module tb_cache_line_refill_unit;
    localparam int unsigned LB = 1024;
    localparam int unsigned NW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          req_wb = 1'b0;
    logic [31:0]   req_wb_addr = '0;
    logic [LB-1:0] req_wb_line = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [LB-1:0] resp_line;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready = 1'b0;
    logic          mem_cmd_we;
    logic [31:0]   mem_cmd_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rdata_valid = 1'b0;
    logic [31:0]   mem_rdata = '0;

    cache_line_refill_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_line(req_wb_line),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_line(resp_line),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
        .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int acc_cyc = 0;

    bit          mem_en = 1'b0;
    int          ready_pct = 100;
    int          dly_max = 1;
    logic        man_valid = 1'b0;
    logic        man_ready = 1'b0;
    logic [31:0] man_data = '0;

    typedef struct {logic [31:0] addr; int due;} rd_t;
    rd_t         rdq[$];
    logic [31:0] rd_log[$];
    int          rd_cyc_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int          wr_cyc_log[$];
    int          stall_viol = 0;
    int          rx_cnt = 0;

    // Memory model: observe on negedge, drive just after posedge.
    always begin
        logic        prev_stall;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        prev_stall = 1'b0;
        p_addr = '0; p_wdata = '0; p_we = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (prev_stall && !(mem_cmd_valid && mem_cmd_we == p_we &&
                                    mem_cmd_addr == p_addr && mem_wdata == p_wdata))
                    stall_viol++;
                prev_stall = mem_cmd_valid && !mem_cmd_ready;
                p_addr = mem_cmd_addr; p_wdata = mem_wdata; p_we = mem_cmd_we;
                if (mem_cmd_valid && mem_cmd_ready) begin
                    if (mem_cmd_we) begin
                        wr_addr_log.push_back(mem_cmd_addr);
                        wr_data_log.push_back(mem_wdata);
                        wr_cyc_log.push_back(cyc + 1);
                    end else begin
                        rd_log.push_back(mem_cmd_addr);
                        rd_cyc_log.push_back(cyc + 1);
                        if (mem_en)
                            rdq.push_back('{mem_cmd_addr, cyc + 1 + int'($urandom_range(dly_max, 1))});
                    end
                end
                if (mem_rdata_valid) rx_cnt++;
            end else begin
                prev_stall = 1'b0;
                rdq.delete();
            end
            @(posedge clk);
            #1;
            if (mem_en) begin
                mem_cmd_ready = ($urandom_range(99, 0) < ready_pct);
                if (rdq.size() > 0 && rdq[0].due <= cyc + 1) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = rdq[0].addr ^ 32'hA5A5_A5A5;
                    void'(rdq.pop_front());
                end else begin
                    mem_rdata_valid = 1'b0;
                end
            end else begin
                mem_cmd_ready   = man_ready;
                mem_rdata_valid = man_valid;
                mem_rdata       = man_data;
            end
        end
    end

    function automatic logic [LB-1:0] exp_line(input logic [31:0] a);
        logic [LB-1:0] l;
        logic [31:0]   b;
        b = a & 32'hFFFF_FF80;
        for (int i = 0; i < NW; i++) l[i*32 +: 32] = (b + 32'(i * 4)) ^ 32'hA5A5_A5A5;
        return l;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic wb, input logic [31:0] wa,
                          input logic [LB-1:0] wl);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL req_accept: req_ready=%b expected 1", req_ready);
        end
        req_addr = a; req_wb = wb; req_wb_addr = wa; req_wb_line = wl; req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        req_valid = 1'b0; req_wb = 1'b0; req_wb_line = '0;
    endtask

    task automatic wait_resp(output int lat);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
        lat = cyc - acc_cyc;
    endtask

    task automatic check_reads(input int rd0, input logic [31:0] base, input string tag);
        int bad = 0;
        n_checks++;
        if (rd_log.size() - rd0 != NW) begin
            n_fail++; $display("FAIL %s_rd_count: got %0d expected %0d", tag, rd_log.size() - rd0, NW);
        end else begin
            for (int i = 0; i < NW; i++) if (rd_log[rd0 + i] !== base + 32'(4 * i)) bad++;
            if (bad != 0) begin n_fail++; $display("FAIL %s_rd_addr: %0d wrong addresses, expected 0", tag, bad); end
        end
    endtask

    task automatic check_writes(input int wr0, input logic [31:0] base, input logic [LB-1:0] wl,
                                input string tag);
        int bad = 0;
        n_checks++;
        if (wr_addr_log.size() - wr0 != NW) begin
            n_fail++; $display("FAIL %s_wr_count: got %0d expected %0d", tag, wr_addr_log.size() - wr0, NW);
        end else begin
            for (int i = 0; i < NW; i++)
                if (wr_addr_log[wr0 + i] !== base + 32'(4 * i) || wr_data_log[wr0 + i] !== wl[i*32 +: 32]) bad++;
            if (bad != 0) begin n_fail++; $display("FAIL %s_wr_data: %0d wrong writes, expected 0", tag, bad); end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            req_valid = 1'($urandom); req_addr = $urandom; req_wb = 1'($urandom);
            req_wb_addr = $urandom; resp_ready = 1'($urandom);
            man_valid = 1'($urandom); man_ready = 1'($urandom); man_data = $urandom;
            @(negedge clk);
            n_checks++;
            if ({req_ready, resp_valid, mem_cmd_valid, mem_cmd_we} !== 4'b0) begin
                n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, resp_valid, mem_cmd_valid, mem_cmd_we});
            end
            n_checks++;
            if (mem_cmd_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_line !== '0) begin
                n_fail++; $display("FAIL reset_data: addr=%h wdata=%h line_nonzero=%b expected 0", mem_cmd_addr, mem_wdata, |resp_line);
            end
        end
        req_valid = 1'b0; req_wb = 1'b0; resp_ready = 1'b0;
        man_valid = 1'b0; man_ready = 1'b0; man_data = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_release_pre_edge: req_ready=%b expected 0", req_ready); end
        @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: req_ready=%b mem_cmd_valid=%b expected 1 0", req_ready, mem_cmd_valid);
        end
        mem_en = 1'b1; ready_pct = 100; dly_max = 1; resp_ready = 1'b1;
    endtask

    task automatic test_clean_miss();
        int lat;
        int rd0 = rd_log.size();
        int wr0 = wr_addr_log.size();
        logic [31:0] w5;
        do_req(32'h0000_1234, 1'b0, 32'h0, '0);
        wait_resp(lat);
        n_checks++;
        if (lat != 34) begin n_fail++; $display("FAIL clean_latency: got %0d expected 34", lat); end
        w5 = resp_line[5*32 +: 32];
        n_checks++;
        if (w5 !== 32'hA5A5_B7B1) begin n_fail++; $display("FAIL clean_word5: got %h expected a5a5b7b1", w5); end
        n_checks++;
        if (resp_line !== exp_line(32'h0000_1200)) begin n_fail++; $display("FAIL clean_line: line differs from expected"); end
        check_reads(rd0, 32'h0000_1200, "clean");
        n_checks++;
        if (wr_addr_log.size() != wr0) begin n_fail++; $display("FAIL clean_no_writes: got %0d writes expected 0", wr_addr_log.size() - wr0); end
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL clean_resp_1cyc: resp_valid=%b req_ready=%b expected 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_dirty_miss();
        int lat;
        int rd0 = rd_log.size();
        int wr0 = wr_addr_log.size();
        logic [LB-1:0] wl;
        for (int i = 0; i < NW; i++) wl[i*32 +: 32] = 32'(i);
        do_req(32'h0000_4000, 1'b1, 32'h0000_8000, wl);
        wait_resp(lat);
        n_checks++;
        if (lat != 66) begin n_fail++; $display("FAIL dirty_latency: got %0d expected 66", lat); end
        check_writes(wr0, 32'h0000_8000, wl, "dirty");
        check_reads(rd0, 32'h0000_4000, "dirty");
        n_checks++;
        if (rd_cyc_log.size() > rd0 && wr_cyc_log.size() >= wr0 + NW) begin
            if (rd_cyc_log[rd0] - wr_cyc_log[wr0 + NW - 1] != 1) begin
                n_fail++; $display("FAIL dirty_rd_after_wr: gap %0d expected 1", rd_cyc_log[rd0] - wr_cyc_log[wr0 + NW - 1]);
            end
        end else begin
            n_fail++; $display("FAIL dirty_rd_after_wr: missing commands, expected reads after writes");
        end
        n_checks++;
        if (resp_line !== exp_line(32'h0000_4000)) begin n_fail++; $display("FAIL dirty_line: line differs from expected"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int lat;
        int rd0 = rd_log.size();
        int wr0 = wr_addr_log.size();
        int sv0 = stall_viol;
        logic [LB-1:0] wl;
        for (int i = 0; i < NW; i++) wl[i*32 +: 32] = 32'hDEAD_0000 | 32'(i);
        ready_pct = 50; dly_max = 5; resp_ready = 1'b0;
        do_req(32'h0003_0044, 1'b1, 32'h0001_0080, wl);
        wait_resp(lat);
        n_checks++;
        if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_timeout: resp_valid=%b expected 1", resp_valid); end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_ctrl: resp_valid=%b req_ready=%b expected 1 0", resp_valid, req_ready);
            end
            n_checks++;
            if (resp_line !== exp_line(32'h0003_0000)) begin n_fail++; $display("FAIL bp_hold_line: cycle %0d line differs from expected", k); end
        end
        check_writes(wr0, 32'h0001_0080, wl, "bp");
        check_reads(rd0, 32'h0003_0000, "bp");
        n_checks++;
        if (stall_viol != sv0) begin n_fail++; $display("FAIL bp_stall_stable: %0d unstable stalls expected 0", stall_viol - sv0); end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: resp_valid=%b expected 0", resp_valid); end
        ready_pct = 100; dly_max = 1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_protocol_edges();
        int lat;
        int rd0;
        mem_en = 1'b0; man_valid = 1'b1; man_data = 32'hBAD0_BAD0;
        repeat (2) @(posedge clk);
        man_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_cmd_valid !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle_rdata_ignored: req_ready=%b cmd=%b resp=%b expected 1 0 0", req_ready, mem_cmd_valid, resp_valid);
        end
        mem_en = 1'b1;
        repeat (2) @(posedge clk);
        rd0 = rd_log.size();
        do_req(32'hFFFF_FF80, 1'b0, 32'h0, '0);
        repeat (4) @(posedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_9000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_req_ready: req_ready=%b expected 0", req_ready); end
        end
        req_valid = 1'b0;
        wait_resp(lat);
        n_checks++;
        if (lat != 34) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 34", lat); end
        n_checks++;
        if (resp_line !== exp_line(32'hFFFF_FF80)) begin n_fail++; $display("FAIL wrap_line: line differs from expected"); end
        n_checks++;
        if (rd_log.size() != rd0 + NW || rd_log[rd_log.size() - 1] !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_last_addr: count %0d last %h expected 32 fffffffc", rd_log.size() - rd0, rd_log[rd_log.size() - 1]);
        end
        check_reads(rd0, 32'hFFFF_FF80, "wrap");
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (mem_cmd_valid !== 1'b0 || rd_log.size() != rd0 + NW) begin
            n_fail++; $display("FAIL busy_req_dropped: cmd=%b reads=%0d expected 0 32", mem_cmd_valid, rd_log.size() - rd0);
        end
    endtask

    task automatic test_reset_mid_read();
        int lat;
        int n = 0;
        int rx0 = rx_cnt;
        do_req(32'h0000_2000, 1'b0, 32'h0, '0);
        while (rx_cnt - rx0 < 10 && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (rx_cnt - rx0 < 10) begin n_fail++; $display("FAIL midrd_progress: got %0d words expected 10", rx_cnt - rx0); end
        #2;
        reset = 1'b0; mem_en = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, mem_cmd_valid, mem_cmd_we} !== 4'b0 || mem_cmd_addr !== 32'h0 || resp_line !== '0) begin
            n_fail++; $display("FAIL midrd_reset_outputs: ctrl=%b addr=%h line_nonzero=%b expected 0",
                               {req_ready, resp_valid, mem_cmd_valid, mem_cmd_we}, mem_cmd_addr, |resp_line);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        man_valid = 1'b1; man_data = 32'h1111_1111;
        repeat (3) @(posedge clk);
        man_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrd_late_rdata: req_ready=%b resp=%b cmd=%b expected 1 0 0", req_ready, resp_valid, mem_cmd_valid);
        end
        mem_en = 1'b1;
        repeat (2) @(posedge clk);
        do_req(32'h0000_5000, 1'b0, 32'h0, '0);
        wait_resp(lat);
        n_checks++;
        if (lat != 34) begin n_fail++; $display("FAIL midrd_new_latency: got %0d expected 34", lat); end
        n_checks++;
        if (resp_line !== exp_line(32'h0000_5000)) begin n_fail++; $display("FAIL midrd_new_line: line differs from expected"); end
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_protocol_edges();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
